// File: rtl/strength_pkg.sv
// Shared types and default widths for the strength accumulator and the sort controller.
package strength_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SUM_W  = 22;
  localparam int unsigned DEF_NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ARGMAX,
    ST_DONE
  } strength_state_t;

endpackage

// File: rtl/strength_acc_lane.sv
// One channel accumulator: zero-extending add with carry-out detection.
// STRENGTH_SAT_EN selects clamping at full scale instead of modulo wrap.
module strength_acc_lane
  import strength_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  sum,
  output logic              carry_c
);

  localparam int unsigned EXT_W = SUM_W + 1;

  logic [SUM_W:0] sum_ext;

  assign sum_ext = {1'b0, sum} + EXT_W'(din);
  assign carry_c = sum_ext[SUM_W];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (add_en) begin
`ifdef STRENGTH_SAT_EN
      // once clamped, further adds keep carrying so the lane stays at full scale
      sum <= carry_c ? '1 : sum_ext[SUM_W-1:0];
`else
      sum <= sum_ext[SUM_W-1:0];
`endif
    end
  end

endmodule

// File: rtl/strength_accumulator.sv
// Per-channel frame strength accumulator with sequential argmax and done pulse.
// Build option STRENGTH_SAT_EN (in strength_acc_lane) clamps lanes instead of wrapping.
module strength_accumulator
  import strength_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned SUM_W  = DEF_SUM_W,
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic [NUM_CH*SUM_W-1:0] sums,
  output logic [CH_W-1:0]         max_ch,
  output logic [SUM_W-1:0]        max_sum,
  output logic [31:0]             beat_cnt,
  output logic                    done,
  output logic                    ch_err,
  output logic                    ovf
);

  strength_state_t   state;
  logic [CH_W-1:0]   idx;
  logic [SUM_W-1:0]  lane_sum [NUM_CH];
  logic [NUM_CH-1:0] lane_add;
  logic [NUM_CH-1:0] lane_carry;
  logic              accept_c;
  logic              ch_ok_c;
  logic              clear_c;
  logic              ovf_hit_c;

  assign accept_c  = in_valid && in_ready;
  assign ch_ok_c   = 32'(in_ch) < NUM_CH;
  assign clear_c   = (state == ST_IDLE) && start;
  assign ovf_hit_c = |(lane_carry & lane_add);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_add[i] = accept_c && ch_ok_c && (in_ch == CH_W'(i));

    strength_acc_lane #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_c),
      .add_en  (lane_add[i]),
      .din     (in_data),
      .sum     (lane_sum[i]),
      .carry_c (lane_carry[i])
    );

    assign sums[i*SUM_W +: SUM_W] = lane_sum[i];
  end

  // Frame control, beat counting and the one-channel-per-cycle argmax walk
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      idx      <= '0;
      max_ch   <= '0;
      max_sum  <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      ch_err   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ACCUM;
            in_ready <= 1'b1;
            beat_cnt <= '0;
            ch_err   <= 1'b0;
            ovf      <= 1'b0;
            max_ch   <= '0;
            max_sum  <= '0;
          end
        end
        ST_ACCUM: begin
          if (accept_c) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (!ch_ok_c)  ch_err <= 1'b1;
            if (ovf_hit_c) ovf    <= 1'b1;
            if (in_last) begin
              state    <= ST_ARGMAX;
              in_ready <= 1'b0;
              idx      <= '0;
            end
          end
        end
        ST_ARGMAX: begin
          // strict compare keeps the lowest index on ties
          if ((idx == '0) || (lane_sum[idx] > max_sum)) begin
            max_sum <= lane_sum[idx];
            max_ch  <= idx;
          end
          if (idx == CH_W'(NUM_CH - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + CH_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/strength_accumulator.md
# strength_accumulator

Parametrised successor to the three-channel strength adder: accumulates per-channel pixel strengths over one frame for any number of colour channels. Once the frame's last beat arrives, it sequentially selects the dominant channel. Sits between the pixel unpacker and the sort controller: consumes tagged pixel beats under a valid/ready handshake and presents frame totals, dominant channel and a one-cycle `done` pulse to the sorter.

## Interface
- `DATA_W`, 8: width of one strength sample.
- `SUM_W`, 22: width of each channel accumulator.
- `NUM_CH`, 3: number of channels (≥2); `CH_W = $clog2(NUM_CH)`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a new frame; honoured only in IDLE.
- `in_valid` in 1: beat present.
- `in_ready` out 1: block accepts beats.
- `in_ch` in CH_W: channel tag of the beat.
- `in_data` in DATA_W: strength sample.
- `in_last` in 1: final beat of the frame.
- `sums` out NUM_CH*SUM_W: channel totals, channel 0 in the LSBs.
- `max_ch` out CH_W: index of the largest total.
- `max_sum` out SUM_W: value of the largest total.
- `beat_cnt` out 32: beats accepted this frame.
- `done` out 1: one-cycle pulse, results valid.
- `ch_err` out 1: sticky; a beat carried `in_ch ≥ NUM_CH`.
- `ovf` out 1: sticky; some accumulator exceeded 2^SUM_W−1.

## Operation
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE → ACCUM on `start`. On that edge, clear all sums, `beat_cnt`, `ch_err`, `ovf`, `max_ch` and `max_sum`.
- ACCUM: `in_ready=1`. A beat is accepted when `in_valid && in_ready`.
  - Add `in_data`, zero-extended, to `sums[in_ch]`.
  - Increment `beat_cnt`.
  - Accepted beat with `in_ch ≥ NUM_CH`: counted, data dropped, `ch_err` set.
  - Accepted beat with `in_last` → ARGMAX. The last beat's data is still added.
- ARGMAX: a CH_W index walks 0..NUM_CH−1, one channel per cycle.
  - Index 0 loads the running max.
  - Later channels replace it only if strictly greater, so ties resolve to the lowest index.
  - After channel NUM_CH−1 → DONE.
- DONE: `done=1` for exactly one cycle, then → IDLE.
- Outputs hold their values in IDLE until the next `start`.
- `start` outside IDLE is ignored.
- `in_valid` outside ACCUM is ignored; no beat is accepted because `in_ready=0`.
- Width rule: sums wrap modulo 2^SUM_W. `ovf` is set on any carry-out regardless of `STRENGTH_SAT_EN`.

## Timing
- Reset values: state IDLE; `in_ready=0`; `sums`, `max_ch`, `max_sum`, `beat_cnt`, `done`, `ch_err`, `ovf` all 0.
- `reset` mid-frame aborts immediately to these values; no `done` is issued.
- Accumulation latency: the sum updates on the accepting edge and is visible the next cycle.
- `in_ready` falls on the edge that accepts the `in_last` beat; back-to-back beats run at 1 per cycle.
- `done` goes high NUM_CH edges after the edge that accepted `in_last` (3 for the default). `max_ch`/`max_sum` are stable when `done=1`.
- `start` asserted in the DONE cycle is ignored; it is honoured from the following IDLE cycle.

## Configuration
- `STRENGTH_SAT_EN` defined: an accumulator clamps at 2^SUM_W−1 instead of wrapping, and stays there for the rest of the frame. `ovf` is still set.
- Not defined: modulo wrap, as described in Operation.

## Structure
- Package `strength_pkg`: FSM state enum `strength_state_t` and the default `DATA_W`/`SUM_W` constants. The sort controller imports the package.
- One sub-module, `strength_acc_lane`: a single accumulator register with an add path and the saturation option, generated NUM_CH times.
- The FSM, argmax walker and counters live in the top level.

## Test plan
- Defaults; `start`; 5 beats ch0=100, 1 beat ch1=100, 2 beats ch2=100, last on the final beat → sums 500/100/200, `max_ch=0`, `max_sum=500`, `beat_cnt=8`, `done` 3 cycles after the last accept.
- Tie: ch1=50 and ch2=50, ch0=10 → `max_ch=1`, `max_sum=50`.
- SUM_W=10, 11 beats ch0=100:
  - with `STRENGTH_SAT_EN` → sum 1023, `ovf=1`;
  - without it → sum 76, `ovf=1`.
- Beat with `in_ch=3` (NUM_CH=3) value 200 → sums unchanged, `beat_cnt` incremented, `ch_err=1` until the next `start`.
- `reset` after 3 beats → all outputs 0 the next cycle, `in_ready=0`, no `done`. A new frame then accumulates from 0.
- NUM_CH=5, `in_valid` toggled every other cycle, `start` pulsed during ACCUM → only valid beats counted, `start` ignored, `done` 5 cycles after the last accept.
